// File: rtl/simon_pkt_out.sv
// simon_pkt_out: output packetiser for the SIMON datapath.
// Buffers up to DEPTH ciphertext blocks (with their info byte) in a circular
// FIFO and presents each one to the host reader as a byte packet:
//   out[0] info, out[1] seq, then word 1 and word 0 bytes MS-first,
//   out[P-1] XOR checksum of the preceding bytes (or 8'h00 when CHK_EN=0).
// Ports:
//   clk, nR             clock, asynchronous active-low reset
//   doneDATA/readDATA   four-phase block handshake with the core
//   outDATA, infoOUT    ciphertext block (word 1 upper) and info byte
//   donePKT/readPKT     four-phase packet handshake with the reader
//   out                 packet bytes, held until the next packet loads
//   fifo_level          blocks buffered, excluding the packet on out
//   fifo_full           fifo_level == DEPTH
module simon_pkt_out #(
    parameter int N      = 16,
    parameter int DEPTH  = 4,
    parameter int CHK_EN = 1
) (
    input  logic                       clk,
    input  logic                       nR,
    input  logic                       doneDATA,
    input  logic [1:0][N-1:0]          outDATA,
    input  logic [7:0]                 infoOUT,
    output logic                       readDATA,
    output logic                       donePKT,
    input  logic                       readPKT,
    output logic [N/4+2:0][7:0]        out,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       fifo_full
);

    localparam int P  = N/4 + 3;
    localparam int NB = N/8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [0:0] IN_IDLE   = 1'b0;
    localparam logic [0:0] IN_ACK    = 1'b1;

    localparam logic [1:0] OUT_EMPTY = 2'd0;
    localparam logic [1:0] OUT_VALID = 2'd1;
    localparam logic [1:0] OUT_WAIT  = 2'd2;

    logic [0:0]            in_state_q,  in_state_d;
    logic [1:0]            out_state_q, out_state_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         count_q, count_d;
    logic [7:0]            seq_q, seq_d;
    logic [P-1:0][7:0]     pkt_q, pkt_d;
    logic                  push, pop, full;
    logic [7:0]            chk;

    logic [7:0]            info_mem [DEPTH];
    logic [1:0][N-1:0]     data_mem [DEPTH];

    assign full = (count_q == LW'(DEPTH));

    // Input handshake: one FIFO write per doneDATA high period.
    always_comb begin
        in_state_d = in_state_q;
        push       = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (doneDATA && !full) begin
                    push       = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!doneDATA) begin
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // Output handshake: the pop only looks at the registered count, so a
    // block written at edge t cannot be popped before edge t+1.
    always_comb begin
        out_state_d = out_state_q;
        seq_d       = seq_q;
        pop         = 1'b0;
        case (out_state_q)
            OUT_EMPTY: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    out_state_d = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (readPKT) begin
                    seq_d       = seq_q + 8'd1;
                    out_state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!readPKT) begin
                    out_state_d = OUT_EMPTY;
                end
            end
            default: out_state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet assembly from the FIFO head entry.
    always_comb begin
        pkt_d    = '0;
        chk      = '0;
        pkt_d[0] = info_mem[rd_ptr_q];
        pkt_d[1] = seq_q;
        for (int unsigned k = 0; k < NB; k++) begin
            pkt_d[2+k]    = data_mem[rd_ptr_q][1][N-1-8*k -: 8];
            pkt_d[2+NB+k] = data_mem[rd_ptr_q][0][N-1-8*k -: 8];
        end
        for (int unsigned b = 0; b < P-1; b++) begin
            chk = chk ^ pkt_d[b];
        end
        pkt_d[P-1] = (CHK_EN != 0) ? chk : 8'h00;
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            pkt_q       <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                pkt_q    <= pkt_d;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            info_mem[wr_ptr_q] <= infoOUT;
            data_mem[wr_ptr_q] <= outDATA;
        end
    end

    assign readDATA   = (in_state_q == IN_ACK);
    assign donePKT    = (out_state_q == OUT_VALID);
    assign out        = pkt_q;
    assign fifo_level = count_q;
    assign fifo_full  = full;

endmodule

// File: tb/tb_simon_pkt_out.sv
// tb_simon_pkt_out: self-checking bench for simon_pkt_out.
// Main instance N=16/DEPTH=4/CHK_EN=1, plus four CHK_EN=0 instances for the
// width sweep (N=24,32,48,64). Expected packets come from a byte-list model.
module tb_simon_pkt_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nR;

    // Main DUT
    logic              doneDATA, readDATA, donePKT, readPKT, full;
    logic [1:0][15:0]  outDATA;
    logic [7:0]        infoOUT;
    logic [6:0][7:0]   out_m;
    logic [2:0]        lvl;

    simon_pkt_out #(.N(16), .DEPTH(4), .CHK_EN(1)) dut (
        .clk(clk), .nR(nR), .doneDATA(doneDATA), .outDATA(outDATA),
        .infoOUT(infoOUT), .readDATA(readDATA), .donePKT(donePKT),
        .readPKT(readPKT), .out(out_m), .fifo_level(lvl), .fifo_full(full)
    );

    // Width-sweep DUTs share the handshake inputs
    logic              doneDATA_s, readPKT_s;
    logic [7:0]        info_s;
    logic [1:0][23:0]  od24;
    logic [1:0][31:0]  od32;
    logic [1:0][47:0]  od48;
    logic [1:0][63:0]  od64;
    logic              rd24, rd32, rd48, rd64, dp24, dp32, dp48, dp64;
    logic              fl24, fl32, fl48, fl64;
    logic [2:0]        lv24, lv32, lv48, lv64;
    logic [8:0][7:0]   o24;
    logic [10:0][7:0]  o32;
    logic [14:0][7:0]  o48;
    logic [18:0][7:0]  o64;
    logic [18:0][7:0]  o24p, o32p, o48p, o64p;

    assign o24p = 152'(o24);
    assign o32p = 152'(o32);
    assign o48p = 152'(o48);
    assign o64p = o64;

    simon_pkt_out #(.N(24), .DEPTH(4), .CHK_EN(0)) dut24 (
        .clk(clk), .nR(nR), .doneDATA(doneDATA_s), .outDATA(od24), .infoOUT(info_s),
        .readDATA(rd24), .donePKT(dp24), .readPKT(readPKT_s), .out(o24),
        .fifo_level(lv24), .fifo_full(fl24));
    simon_pkt_out #(.N(32), .DEPTH(4), .CHK_EN(0)) dut32 (
        .clk(clk), .nR(nR), .doneDATA(doneDATA_s), .outDATA(od32), .infoOUT(info_s),
        .readDATA(rd32), .donePKT(dp32), .readPKT(readPKT_s), .out(o32),
        .fifo_level(lv32), .fifo_full(fl32));
    simon_pkt_out #(.N(48), .DEPTH(4), .CHK_EN(0)) dut48 (
        .clk(clk), .nR(nR), .doneDATA(doneDATA_s), .outDATA(od48), .infoOUT(info_s),
        .readDATA(rd48), .donePKT(dp48), .readPKT(readPKT_s), .out(o48),
        .fifo_level(lv48), .fifo_full(fl48));
    simon_pkt_out #(.N(64), .DEPTH(4), .CHK_EN(0)) dut64 (
        .clk(clk), .nR(nR), .doneDATA(doneDATA_s), .outDATA(od64), .infoOUT(info_s),
        .readDATA(rd64), .donePKT(dp64), .readPKT(readPKT_s), .out(o64),
        .fifo_level(lv64), .fifo_full(fl64));

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_acc = 0;

    typedef struct packed {
        logic [7:0]  info;
        logic [15:0] w1;
        logic [15:0] w0;
    } blk_t;

    blk_t       exp_q[$];
    logic [7:0] seq_m, seq_sw;

    // Reference packet: byte list info, seq, word1 MS-first, word0 MS-first,
    // then checksum; unused upper bytes are zero.
    function automatic logic [18:0][7:0] model_pkt(input int n, input bit chk_en,
            input logic [7:0] info, input logic [7:0] seq,
            input logic [63:0] w1, input logic [63:0] w0);
        logic [7:0]       b[$];
        logic [7:0]       x;
        logic [18:0][7:0] r;
        b.push_back(info);
        b.push_back(seq);
        for (int i = n/8 - 1; i >= 0; i--) b.push_back(8'(w1 >> (8*i)));
        for (int i = n/8 - 1; i >= 0; i--) b.push_back(8'(w0 >> (8*i)));
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(chk_en ? x : 8'h00);
        r = '0;
        foreach (b[i]) r[i] = b[i];
        return r;
    endfunction

    task automatic next_exp(output logic [6:0][7:0] e);
        blk_t             b;
        logic [18:0][7:0] m;
        if (exp_q.size() == 0) begin
            e = 'x;
        end else begin
            b = exp_q.pop_front();
            m = model_pkt(16, 1'b1, b.info, seq_m, 64'(b.w1), 64'(b.w0));
            e = m[6:0];
            seq_m = seq_m + 8'd1;
        end
    endtask

    task automatic rnd_blk(output blk_t b);
        b.info = 8'($urandom);
        b.w1   = 16'($urandom);
        b.w0   = 16'($urandom);
    endtask

    task automatic do_reset;
        @(negedge clk);
        nR = 1'b0;
        doneDATA = 1'b0; readPKT = 1'b0; doneDATA_s = 1'b0; readPKT_s = 1'b0;
        repeat (2) @(negedge clk);
        nR = 1'b1;
        exp_q.delete();
        seq_m  = 8'h00;
        seq_sw = 8'h00;
    endtask

    task automatic send_blk(input blk_t b, output bit ok);
        int unsigned c;
        ok = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        infoOUT = b.info; outDATA[1] = b.w1; outDATA[0] = b.w0; doneDATA = 1'b1;
        c = 0;
        while (readDATA !== 1'b1 && c < 300) begin @(negedge clk); c++; end
        if (readDATA !== 1'b1) ok = 1'b0;
        doneDATA = 1'b0;
        c = 0;
        while (readDATA !== 1'b0 && c < 10) begin @(negedge clk); c++; end
        if (readDATA !== 1'b0) ok = 1'b0;
    endtask

    task automatic recv_pkt(output logic [6:0][7:0] p, output bit ok);
        int unsigned c;
        ok = 1'b1;
        @(negedge clk);
        c = 0;
        while (donePKT !== 1'b1 && c < 300) begin @(negedge clk); c++; end
        if (donePKT !== 1'b1) ok = 1'b0;
        p = out_m;
        readPKT = 1'b1;
        @(negedge clk);
        c = 0;
        while (donePKT !== 1'b0 && c < 10) begin @(negedge clk); c++; end
        if (donePKT !== 1'b0) ok = 1'b0;
        readPKT = 1'b0;
        n_acc++;
    endtask

    task automatic test_reset;
        nR = 1'b1;
        doneDATA = 1'b0; readPKT = 1'b0; outDATA = '0; infoOUT = '0;
        doneDATA_s = 1'b0; readPKT_s = 1'b0; info_s = '0;
        od24 = '0; od32 = '0; od48 = '0; od64 = '0;
        #3 nR = 1'b0;
        #1;
        n_cmp++;
        if ({readDATA, donePKT, full} !== 3'b000 || lvl !== 3'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: rd/done/full=%b lvl=%0d, want 000 lvl=0",
                     {readDATA, donePKT, full}, lvl);
        end
        n_cmp++;
        if (out_m !== '0) begin
            n_err++;
            $display("FAIL reset_out: got %h want 0", out_m);
        end
        repeat (2) @(negedge clk);
        nR = 1'b1;
        exp_q.delete();
        seq_m = 8'h00; seq_sw = 8'h00;
    endtask

    task automatic test_single;
        @(negedge clk);
        infoOUT = 8'hA5; outDATA[1] = 16'h1234; outDATA[0] = 16'h5678; doneDATA = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (readDATA !== 1'b1 || donePKT !== 1'b0 || lvl !== 3'd1) begin
            n_err++;
            $display("FAIL single_capture: rd=%b done=%b lvl=%0d, want 1 0 1",
                     readDATA, donePKT, lvl);
        end
        @(negedge clk);
        n_cmp++;
        if (donePKT !== 1'b1 || lvl !== 3'd0) begin
            n_err++;
            $display("FAIL single_latency: done=%b lvl=%0d, want 1 0", donePKT, lvl);
        end
        n_cmp++;
        if (out_m !== 56'hAD_78_56_34_12_00_A5) begin
            n_err++;
            $display("FAIL single_packet: got %h want ad78563412 00a5", out_m);
        end
        @(negedge clk);
        doneDATA = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (readDATA !== 1'b0) begin
            n_err++;
            $display("FAIL single_rd_fall: rd=%b want 0", readDATA);
        end
        readPKT = 1'b1;
        @(negedge clk);
        readPKT = 1'b0;
        n_cmp++;
        if (donePKT !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: done=%b want 0", donePKT);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (donePKT !== 1'b0 || out_m !== 56'hAD_78_56_34_12_00_A5) begin
            n_err++;
            $display("FAIL single_hold: done=%b out=%h want 0 ad7856341200a5", donePKT, out_m);
        end
        seq_m = 8'h01;
    endtask

    task automatic test_simul_write_pop;
        blk_t            b;
        bit              ok;
        logic [6:0][7:0] got, e;
        int unsigned     c;
        for (int i = 0; i < 3; i++) begin
            rnd_blk(b);
            send_blk(b, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL simul_send%0d: handshake timeout", i); end
        end
        n_cmp++;
        if (lvl !== 3'd2 || donePKT !== 1'b1) begin
            n_err++;
            $display("FAIL simul_setup: lvl=%0d done=%b want 2 1", lvl, donePKT);
        end
        next_exp(e);
        n_cmp++;
        if (out_m !== e) begin
            n_err++;
            $display("FAIL simul_head: got %h want %h", out_m, e);
        end
        readPKT = 1'b1;
        @(negedge clk);
        readPKT = 1'b0;
        @(negedge clk);
        rnd_blk(b);
        exp_q.push_back(b);
        infoOUT = b.info; outDATA[1] = b.w1; outDATA[0] = b.w0; doneDATA = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (lvl !== 3'd2 || readDATA !== 1'b1 || donePKT !== 1'b1) begin
            n_err++;
            $display("FAIL simul_level: lvl=%0d rd=%b done=%b want 2 1 1", lvl, readDATA, donePKT);
        end
        doneDATA = 1'b0;
        c = 0;
        while (readDATA !== 1'b0 && c < 10) begin @(negedge clk); c++; end
        for (int i = 0; i < 3; i++) begin
            recv_pkt(got, ok);
            next_exp(e);
            n_cmp++;
            if (!ok || got !== e) begin
                n_err++;
                $display("FAIL simul_drain%0d: got %h want %h ok=%b", i, got, e, ok);
            end
        end
        n_cmp++;
        if (lvl !== 3'd0) begin
            n_err++;
            $display("FAIL simul_empty: lvl=%0d want 0", lvl);
        end
    endtask

    task automatic test_backpressure;
        blk_t            b;
        bit              ok, rose;
        logic [6:0][7:0] got, e;
        bit              stuck0;
        int unsigned     acc_at_rise;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rnd_blk(b);
            send_blk(b, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL bp_send%0d: handshake timeout", i); end
        end
        n_cmp++;
        if (full !== 1'b1 || lvl !== 3'd4 || donePKT !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full: full=%b lvl=%0d done=%b want 1 4 1", full, lvl, donePKT);
        end
        rnd_blk(b);
        exp_q.push_back(b);
        @(negedge clk);
        infoOUT = b.info; outDATA[1] = b.w1; outDATA[0] = b.w0; doneDATA = 1'b1;
        stuck0 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (readDATA !== 1'b0) stuck0 = 1'b0;
        end
        n_cmp++;
        if (!stuck0) begin
            n_err++;
            $display("FAIL bp_blocked: rd rose while full, want 0");
        end
        n_acc = 0;
        acc_at_rise = 0;
        rose = 1'b0;
        fork
            begin
                int unsigned c;
                c = 0;
                while (readDATA !== 1'b1 && c < 300) begin @(negedge clk); c++; end
                rose = (readDATA === 1'b1);
                acc_at_rise = n_acc;
                doneDATA = 1'b0;
                c = 0;
                while (readDATA !== 1'b0 && c < 10) begin @(negedge clk); c++; end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [6:0][7:0] g, x;
                    bit              k;
                    recv_pkt(g, k);
                    next_exp(x);
                    n_cmp++;
                    if (!k || g !== x || g[1] !== 8'(i)) begin
                        n_err++;
                        $display("FAIL bp_pkt%0d: got %h want %h ok=%b", i, g, x, k);
                    end
                end
            end
        join
        n_cmp++;
        if (!rose || acc_at_rise < 1) begin
            n_err++;
            $display("FAIL bp_release: rose=%b accepted_before=%0d want 1 >=1", rose, acc_at_rise);
        end
        got = '0; e = '0;
    endtask

    task automatic test_reset_mid;
        blk_t            b;
        bit              ok, quiet;
        logic [6:0][7:0] got, e;
        for (int i = 0; i < 3; i++) begin
            rnd_blk(b);
            send_blk(b, ok);
        end
        n_cmp++;
        if (donePKT !== 1'b1 || lvl !== 3'd2) begin
            n_err++;
            $display("FAIL rmid_setup: done=%b lvl=%0d want 1 2", donePKT, lvl);
        end
        #2 nR = 1'b0;
        #1;
        n_cmp++;
        if ({readDATA, donePKT, full} !== 3'b000 || lvl !== 3'd0 || out_m !== '0) begin
            n_err++;
            $display("FAIL rmid_zero: rd/done/full=%b lvl=%0d out=%h want all 0",
                     {readDATA, donePKT, full}, lvl, out_m);
        end
        @(negedge clk);
        nR = 1'b1;
        exp_q.delete();
        seq_m = 8'h00; seq_sw = 8'h00;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (donePKT !== 1'b0 || lvl !== 3'd0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_err++;
            $display("FAIL rmid_stale: stale packet or level after reset, want none");
        end
        rnd_blk(b);
        send_blk(b, ok);
        recv_pkt(got, ok);
        next_exp(e);
        n_cmp++;
        if (!ok || got !== e || got[1] !== 8'h00) begin
            n_err++;
            $display("FAIL rmid_first: got %h want %h (seq 00) ok=%b", got, e, ok);
        end
    endtask

    task automatic test_seq_wrap;
        logic [7:0] last_seq;
        do_reset();
        last_seq = 8'hxx;
        fork
            begin
                for (int i = 0; i < 257; i++) begin
                    blk_t b;
                    bit   k;
                    rnd_blk(b);
                    send_blk(b, k);
                end
            end
            begin
                for (int i = 0; i < 257; i++) begin
                    logic [6:0][7:0] g, x;
                    bit              k;
                    recv_pkt(g, k);
                    next_exp(x);
                    n_cmp++;
                    if (!k || g !== x) begin
                        n_err++;
                        $display("FAIL wrap_pkt%0d: got %h want %h ok=%b", i, g, x, k);
                    end
                    last_seq = g[1];
                end
            end
        join
        n_cmp++;
        if (last_seq !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_last_seq: got %h want 00", last_seq);
        end
    endtask

    task automatic test_width_sweep;
        logic [63:0]      w1, w0;
        logic [7:0]       info;
        logic [18:0][7:0] m;
        int unsigned      c;
        bit               hs;
        for (int it = 0; it < 3; it++) begin
            w1 = {32'($urandom), 32'($urandom)};
            w0 = {32'($urandom), 32'($urandom)};
            info = 8'($urandom);
            @(negedge clk);
            info_s = info;
            od24[1] = w1[23:0]; od24[0] = w0[23:0];
            od32[1] = w1[31:0]; od32[0] = w0[31:0];
            od48[1] = w1[47:0]; od48[0] = w0[47:0];
            od64[1] = w1;       od64[0] = w0;
            doneDATA_s = 1'b1;
            hs = 1'b1;
            c = 0;
            while ({rd24, rd32, rd48, rd64} !== 4'hF && c < 20) begin @(negedge clk); c++; end
            if ({rd24, rd32, rd48, rd64} !== 4'hF) hs = 1'b0;
            doneDATA_s = 1'b0;
            c = 0;
            while ({dp24, dp32, dp48, dp64} !== 4'hF && c < 20) begin @(negedge clk); c++; end
            if ({dp24, dp32, dp48, dp64} !== 4'hF) hs = 1'b0;
            n_cmp++;
            if (!hs) begin n_err++; $display("FAIL sweep_hs%0d: handshake timeout", it); end
            m = model_pkt(24, 1'b0, info, seq_sw, w1, w0);
            n_cmp++;
            if (o24p !== m) begin n_err++; $display("FAIL sweep24_%0d: got %h want %h", it, o24p, m); end
            m = model_pkt(32, 1'b0, info, seq_sw, w1, w0);
            n_cmp++;
            if (o32p !== m) begin n_err++; $display("FAIL sweep32_%0d: got %h want %h", it, o32p, m); end
            m = model_pkt(48, 1'b0, info, seq_sw, w1, w0);
            n_cmp++;
            if (o48p !== m) begin n_err++; $display("FAIL sweep48_%0d: got %h want %h", it, o48p, m); end
            m = model_pkt(64, 1'b0, info, seq_sw, w1, w0);
            n_cmp++;
            if (o64p !== m) begin n_err++; $display("FAIL sweep64_%0d: got %h want %h", it, o64p, m); end
            readPKT_s = 1'b1;
            @(negedge clk);
            c = 0;
            while ({dp24, dp32, dp48, dp64} !== 4'h0 && c < 10) begin @(negedge clk); c++; end
            readPKT_s = 1'b0;
            seq_sw = seq_sw + 8'd1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simul_write_pop();
        test_backpressure();
        test_reset_mid();
        test_seq_wrap();
        test_width_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simon_pkt_out.md
# simon_pkt_out

Parametrised output packetiser for the SIMON datapath. It sits between the SIMON core's ciphertext output and the host-side packet reader. It buffers up to DEPTH completed blocks in an internal FIFO, so the core is not stalled by a slow reader. Each block is framed as a byte packet with an info byte, an internally generated sequence number, the data bytes and an optional XOR checksum.

## Interface
- N, 16, SIMON word width in bits; legal values 16, 24, 32, 48, 64; one block = 2 words.
- DEPTH, 4, FIFO depth in blocks; power of two, ≥ 2.
- CHK_EN, 1, 1 = checksum byte computed; 0 = checksum byte driven 8'h00.
- Derived: P = N/4 + 3 packet bytes.
- clk  in  1  system clock; all state changes on rising edge.
- nR  in  1  reset, asynchronous, active-low.
- doneDATA  in  1  core block-valid request (four-phase).
- outDATA  in  [1:0][N-1:0]  ciphertext block; word 1 is the upper word.
- infoOUT  in  8  info/status byte, captured with the block.
- readDATA  out  1  capture acknowledge to the core (four-phase).
- donePKT  out  1  packet valid to the reader (four-phase).
- readPKT  in  1  reader acknowledge (four-phase).
- out  out  [P-1:0][7:0]  packet bytes.
- fifo_level  out  $clog2(DEPTH)+1  number of blocks held, excluding the packet on out.
- fifo_full  out  1  fifo_level == DEPTH.

## Operation
- Input side: two states, IN_IDLE and IN_ACK.
  - IN_IDLE: when doneDATA=1 and fifo_full=0, write {infoOUT, outDATA} into the FIFO and go to IN_ACK.
  - IN_ACK: readDATA=1. Stay while doneDATA=1. When doneDATA=0, go to IN_IDLE with readDATA=0.
  - Exactly one FIFO write per doneDATA high period.
- FIFO: circular buffer with wrap-around read/write pointers. A write is refused while full, even if a pop happens in the same cycle; the core simply waits in IN_IDLE.
- Output side: three states, OUT_EMPTY, OUT_VALID and OUT_WAIT.
  - OUT_EMPTY: when fifo_level > 0, pop the head entry, load the packet register and go to OUT_VALID.
  - OUT_VALID: donePKT=1. When readPKT=1, increment seq and go to OUT_WAIT.
  - OUT_WAIT: donePKT=0. When readPKT=0, go to OUT_EMPTY.
- Packet layout:
  - out[0] = info.
  - out[1] = seq, the value before increment.
  - out[2 .. 1+N/8] = outDATA[1] bytes, MS byte first.
  - out[2+N/8 .. 1+N/4] = outDATA[0] bytes, MS byte first.
  - out[P-1] = XOR of out[0..P-2] when CHK_EN=1, else 8'h00.
- seq: 8-bit counter; increments only on packet acceptance; wraps 8'hFF → 8'h00.
- out holds the last delivered packet until the next load, including through OUT_WAIT and OUT_EMPTY.

## Timing
- Reset values (async, immediate on nR=0):
  - readDATA=0, donePKT=0, out=all zero.
  - seq=0, fifo_level=0, fifo_full=0.
  - Both FSMs in their IDLE/EMPTY state; FIFO emptied.
  - Reset mid-packet discards all buffered blocks. The first packet after reset carries seq 0.
- Capture: doneDATA sampled high at edge t (not full) → write at t; readDATA=1 after t.
- readDATA falls after the first edge at which doneDATA is sampled 0.
- Latency, empty FIFO: write at edge t → pop at t+1 → donePKT=1 after t+1. There is no write-to-read bypass.
- fifo_level counts the written entry after t and drops back after t+1.
- Acceptance: readPKT sampled 1 at edge u → donePKT=0 after u; seq incremented at u.
- The next packet loads no earlier than the first edge after readPKT is sampled 0. If fifo_level > 0, donePKT rises 1 cycle after that edge.
- Simultaneous FIFO write and pop (not full): both happen; fifo_level is unchanged.
- Write while full: blocked. readDATA stays 0 until a pop frees a slot; capture occurs the cycle after that pop.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset then single block, N=16, CHK_EN=1: outDATA={16'h1234,16'h5678}, infoOUT=8'hA5, doneDATA high for 3 cycles.
  - Required: readDATA rises 1 cycle after capture; donePKT rises 2 cycles after capture.
  - Required: out = {chk=8'hA5^8'h00^8'h12^8'h34^8'h56^8'h78, 78, 56, 34, 12, 00, A5}, listed from out[P-1] down to out[0].
- Sequence wrap: deliver 257 packets with prompt readPKT. Required: out[1] runs 0..255, then 0; the 257th packet has seq 8'h00.
- Back-pressure, DEPTH=4: readPKT held low while the core offers 6 blocks.
  - Required: one block is held in out; fifo_full=1 with fifo_level=4.
  - Required: the 6th readDATA stays 0 until the first readPKT acceptance.
  - Required: all 6 packets emerge in order with seq 0..5.
- Width sweep N=24,32,48,64 with CHK_EN=0: required P = 9, 11, 15, 19 bytes, correct byte order, and checksum byte = 8'h00.
- Reset mid-operation: nR=0 while donePKT=1 and fifo_level=2.
  - Required: all outputs 0 immediately.
  - Required: after release, the next block yields seq 0 and no stale packet appears.
- Simultaneous write and pop: a doneDATA capture coincides with a pop, with fifo_level=2. Required: fifo_level stays 2; no block is lost or duplicated.
